// File: rtl/dsc_reg_snapshot_if.sv
// dsc_reg_snapshot_if: register-file debug port and debug-screen read port bundle
interface dsc_reg_snapshot_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              cpu_rd_busy;
  logic [ADDR_W-1:0] ds_addr;
  logic [DATA_W-1:0] ds_data;

  modport master (
    output rf_addr,
    output ds_data,
    input  rf_data,
    input  cpu_rd_busy,
    input  ds_addr
  );

  modport slave (
    input  rf_addr,
    input  ds_data,
    output rf_data,
    output cpu_rd_busy,
    output ds_addr
  );
endinterface

// File: rtl/dsc_reg_snapshot.sv
// dsc_reg_snapshot: frame-synchronous CPU register snapshot into a shadow buffer for the debug screen.
// Optional double-buffered shadow enabled by defining DSC_SNAP_DBUF_EN.
module dsc_reg_snapshot #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             vsync,
  input  logic             freeze,
  dsc_reg_snapshot_if.master bus,
  output logic             snap_busy,
  output logic             snap_done,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  localparam logic VS_ACT = 1'(VSYNC_POL);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic              vsync_d;
  logic              vs_edge;
  logic              wr_en;

  assign vs_edge     = (vsync == VS_ACT) && (vsync_d != VS_ACT);
  assign wr_en       = (state == COPY) && !bus.cpu_rd_busy;
  assign snap_busy   = (state == COPY);
  assign snap_done   = (state == DONE);
  assign bus.rf_addr = (state == COPY) ? idx : '0;

  // vsync delay flop for assert-edge detection; resets to the inactive level
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) vsync_d <= ~VS_ACT;
    else         vsync_d <= vsync;

  // FSM state and copy index registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end

  // next-state: start on an unfrozen vsync edge, step idx on unstalled cycles, one DONE cycle
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: if (vs_edge && !freeze) begin
        state_nx = COPY;
        idx_nx   = '0;
      end
      COPY: if (!bus.cpu_rd_busy) begin
        state_nx = (idx == LAST) ? DONE : COPY;
        idx_nx   = (idx == LAST) ? '0 : idx + 1'b1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // sticky overrun: a new frame started before the previous copy finished
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)                          overrun <= 1'b0;
    else if ((state == COPY) && vs_edge)  overrun <= 1'b1;

  // completed-snapshot counter, wraps naturally
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)              frame_cnt <= '0;
    else if (state == DONE)   frame_cnt <= frame_cnt + 1'b1;

`ifdef DSC_SNAP_DBUF_EN
  logic              bank;
  logic [DATA_W-1:0] shadow [2][NUM_REGS];

  // front-bank select flips as DONE is left so the screen only sees whole snapshots
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)             bank <= 1'b0;
    else if (state == DONE)  bank <= ~bank;

  // copy writes the back bank; both banks clear on reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)     shadow <= '{default: '{default: '0}};
    else if (wr_en)  shadow[~bank][idx] <= bus.rf_data;

  assign bus.ds_data = shadow[bank][bus.ds_addr];
`else
  logic [DATA_W-1:0] shadow [NUM_REGS];

  // single bank updated in place; the copy runs during vertical blanking
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)     shadow <= '{default: '0};
    else if (wr_en)  shadow[idx] <= bus.rf_data;

  assign bus.ds_data = shadow[bus.ds_addr];
`endif

endmodule

// File: tb/tb_dsc_reg_snapshot.sv
// tb_dsc_reg_snapshot: directed table-driven bench for dsc_reg_snapshot (both DSC_SNAP_DBUF_EN builds)
module tb_dsc_reg_snapshot;

`ifdef DSC_SNAP_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef struct {
    string       nm;
    bit          frz;
    bit          frz_mid;
    bit          stall;
    bit          inj;
    bit          flat;
    logic [31:0] k;
    int          exp_busy;
    int          exp_done;
    logic [15:0] exp_cnt;
    bit          exp_ovr;
    bit          copies;
  } row_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vsync;
  logic        freeze;
  logic        snap_busy;
  logic        snap_done;
  logic        overrun;
  logic [15:0] frame_cnt;
  logic        rf_flat;
  logic [31:0] rf_k;
  logic [31:0] exp_sh [32];
  int          total = 0;
  int          passed = 0;
  row_t        rows [4];

  dsc_reg_snapshot_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  dsc_reg_snapshot dut (
    .clk       (clk),
    .resetn    (resetn),
    .vsync     (vsync),
    .freeze    (freeze),
    .bus       (bus),
    .snap_busy (snap_busy),
    .snap_done (snap_done),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  assign bus.rf_data = rf_flat ? rf_k : 32'(bus.rf_addr) * rf_k;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic readback(input string nm);
    for (int n = 0; n < 32; n++) begin
      bus.ds_addr = 5'(n);
      #1;
      chk($sformatf("%s ds[%0d]", nm, n), bus.ds_data, exp_sh[n]);
    end
  endtask

  task automatic vs_fall;
    vsync = 1'b1;
    tick;
    tick;
    vsync = 1'b0;
  endtask

  task automatic run_row(input row_t r);
    int busy = 0;
    int done_at = 0;
    freeze  = r.frz;
    rf_flat = r.flat;
    rf_k    = r.k;
    vs_fall;
    for (int t = 1; t <= (r.copies ? 200 : 40); t++) begin
      tick;
      if (snap_busy) busy++;
      bus.cpu_rd_busy = snap_busy && r.stall && busy[0];
      if (r.inj && busy == 8) vsync = 1'b1;
      if (r.inj && busy == 10) vsync = 1'b0;
      if (r.frz_mid && busy == 4) freeze = 1'b1;
      if (!r.stall && snap_busy && busy == 5) begin
        chk({r.nm, " rf_addr@5"}, 32'(bus.rf_addr), 32'd4);
        if (r.inj) begin
          bus.ds_addr = 5'd4;
          #1;
          chk({r.nm, " ds[4] same-cycle old"}, bus.ds_data, 32'h04040404);
          bus.ds_addr = 5'd1;
          #1;
          chk({r.nm, " ds[1] mid-copy"}, bus.ds_data, DBUF ? 32'h01010101 : 32'hA5A5A5A5);
        end
      end
      if (snap_done && done_at == 0) begin
        done_at = t;
        if (r.inj) begin
          bus.ds_addr = 5'd1;
          #1;
          chk({r.nm, " ds[1] at done"}, bus.ds_data, DBUF ? 32'h01010101 : 32'hA5A5A5A5);
        end
        tick;
        chk({r.nm, " done pulse width"}, 32'(snap_done), 32'd0);
        if (r.inj) chk({r.nm, " ds[1] after done"}, bus.ds_data, 32'hA5A5A5A5);
        break;
      end
    end
    freeze = 1'b0;
    bus.cpu_rd_busy = 1'b0;
    chk({r.nm, " busy cycles"}, 32'(busy), 32'(r.exp_busy));
    chk({r.nm, " done cycle"}, 32'(done_at), 32'(r.exp_done));
    chk({r.nm, " frame_cnt"}, 32'(frame_cnt), 32'(r.exp_cnt));
    tick;
    chk({r.nm, " overrun"}, 32'(overrun), 32'(r.exp_ovr));
    if (r.copies)
      for (int n = 0; n < 32; n++) exp_sh[n] = r.flat ? r.k : 32'(n) * r.k;
    readback(r.nm);
  endtask

  task automatic reset_mid_copy;
    bit got = 1'b0;
    int busy = 0;
    rf_flat = 1'b0;
    rf_k    = 32'h01010101;
    vs_fall;
    for (int t = 1; t <= 60; t++) begin
      tick;
      if (snap_busy) busy++;
      if (busy == 13) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst reached idx12", 32'(got), 32'd1);
    resetn = 1'b0;
    vsync  = 1'b1;
    #1;
    chk("rst async busy", 32'(snap_busy), 32'd0);
    tick;
    tick;
    chk("rst snap_done", 32'(snap_done), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst rf_addr", 32'(bus.rf_addr), 32'd0);
    for (int n = 0; n < 32; n++) exp_sh[n] = '0;
    readback("rst");
    resetn = 1'b1;
    tick;
    chk("rst no spurious copy", 32'(snap_busy), 32'd0);
  endtask

  initial begin
    rows[0] = '{nm:"basic", frz:0, frz_mid:0, stall:0, inj:0, flat:0, k:32'h01010101,
                exp_busy:32, exp_done:33, exp_cnt:16'd1, exp_ovr:0, copies:1};
    rows[1] = '{nm:"freeze", frz:1, frz_mid:0, stall:0, inj:0, flat:1, k:32'hDEADBEEF,
                exp_busy:0, exp_done:0, exp_cnt:16'd1, exp_ovr:0, copies:0};
    rows[2] = '{nm:"overrun", frz:0, frz_mid:1, stall:0, inj:1, flat:1, k:32'hA5A5A5A5,
                exp_busy:32, exp_done:33, exp_cnt:16'd2, exp_ovr:1, copies:1};
    rows[3] = '{nm:"stall", frz:0, frz_mid:0, stall:1, inj:0, flat:0, k:32'h01010101,
                exp_busy:64, exp_done:65, exp_cnt:16'd1, exp_ovr:0, copies:1};
    resetn          = 1'b0;
    vsync           = 1'b1;
    freeze          = 1'b0;
    bus.cpu_rd_busy = 1'b0;
    bus.ds_addr     = '0;
    rf_flat         = 1'b0;
    rf_k            = 32'h01010101;
    for (int n = 0; n < 32; n++) exp_sh[n] = '0;
    tick;
    tick;
    chk("reset snap_busy", 32'(snap_busy), 32'd0);
    chk("reset snap_done", 32'(snap_done), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset rf_addr", 32'(bus.rf_addr), 32'd0);
    bus.ds_addr = 5'd31;
    #1;
    chk("reset ds[31]", bus.ds_data, 32'd0);
    resetn = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset_mid_copy();
      run_row(rows[i]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
